// File: rtl/phy_rx_pkg.sv
// -----------------------------------------------------------------------------
// phy_rx_pkg
// Shared definitions for the serial PHY receive path:
//   - rx_state_t        : character-alignment FSM states
//   - DEFAULT_COM_CHAR  : default alignment / frame-boundary character
//   - DEFAULT_IDL_CHAR  : default idle character
//   - ptr_width()       : lane-pointer width helper (never narrower than 1 bit)
// The character constants are shared with the transmit side so both ends of the
// link agree on framing.
// -----------------------------------------------------------------------------
package phy_rx_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_SYNCED  = 2'd2
   } rx_state_t;

   localparam logic [7:0] DEFAULT_COM_CHAR = 8'hBC;
   localparam logic [7:0] DEFAULT_IDL_CHAR = 8'h7C;

   // A single lane still needs a 1-bit pointer register.
   function automatic int ptr_width(input int num_lanes);
      return (num_lanes > 1) ? $clog2(num_lanes) : 1;
   endfunction

endpackage

// File: rtl/phy_rx_aligner.sv
// -----------------------------------------------------------------------------
// phy_rx_aligner
// Recovers character alignment from the serial bit stream.
//   clk_32f  : serial bit clock
//   reset_L  : asynchronous active-low reset
//   data_in  : serial data, MSB of each character first
//   char     : current contents of the receive shift register
//   char_stb : character boundary while synced (char holds a whole character)
//   active   : high while synced
// SEARCH hunts for COM on every bit; once found, the bit phase is fixed and
// ACQUIRE requires SYNC_COUNT consecutive COMs on character boundaries before
// declaring SYNCED. A non-COM during ACQUIRE drops back to the bit-wise hunt.
// -----------------------------------------------------------------------------
module phy_rx_aligner
   import phy_rx_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] COM_CHAR   = WIDTH'(DEFAULT_COM_CHAR),
   parameter int               SYNC_COUNT = 4
) (
   input  logic             clk_32f,
   input  logic             reset_L,
   input  logic             data_in,
   output logic [WIDTH-1:0] char,
   output logic             char_stb,
   output logic             active
);

   localparam int BW = $clog2(WIDTH);
   localparam int CW = $clog2(SYNC_COUNT + 1);

   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [CW-1:0] COM_GOAL = CW'(SYNC_COUNT);

   rx_state_t        state, state_nx;
   logic [WIDTH-1:0] sr;
   logic [BW-1:0]    bit_cnt, bit_cnt_nx;
   logic [CW-1:0]    com_cnt, com_cnt_nx;
   logic             boundary;
   logic             is_com;

   // The counter is cleared on the edge that recognises COM, so the next
   // complete character is in sr exactly WIDTH cycles later.
   assign boundary = (bit_cnt == BIT_LAST);
   assign is_com   = (sr == COM_CHAR);

   // NOTE: every variable written here gets a default first so no path leaves
   // it unassigned -- otherwise synthesis infers a latch.
   always_comb begin
      state_nx   = state;
      bit_cnt_nx = boundary ? '0 : bit_cnt + 1'b1;
      com_cnt_nx = com_cnt;

      unique case (state)
         ST_SEARCH: begin
            if (is_com) begin
               bit_cnt_nx = '0;
               com_cnt_nx = CW'(1);
               state_nx   = (SYNC_COUNT == 1) ? ST_SYNCED : ST_ACQUIRE;
            end
         end
         ST_ACQUIRE: begin
            if (boundary) begin
               if (is_com) begin
                  com_cnt_nx = com_cnt + 1'b1;
                  if (com_cnt + 1'b1 == COM_GOAL) begin
                     state_nx = ST_SYNCED;
                  end
               end else begin
                  com_cnt_nx = '0;
                  state_nx   = ST_SEARCH;
               end
            end
         end
         ST_SYNCED: begin
            // Held until reset; loss-of-sync is handled elsewhere.
         end
         default: state_nx = ST_SEARCH;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         state   <= ST_SEARCH;
         sr      <= '0;
         bit_cnt <= '0;
         com_cnt <= '0;
      end else begin
         state   <= state_nx;
         sr      <= {sr[WIDTH-2:0], data_in};
         bit_cnt <= bit_cnt_nx;
         com_cnt <= com_cnt_nx;
      end
   end

   assign char     = sr;
   assign char_stb = (state == ST_SYNCED) && boundary;
   assign active   = (state == ST_SYNCED);

endmodule

// File: rtl/phy_rx_lanes.sv
// -----------------------------------------------------------------------------
// phy_rx_lanes
// Serial PHY receiver: aligns to COM characters, strips COM/IDL framing and
// distributes data characters round-robin over NUM_LANES output lanes.
//   clk_32f      : serial bit clock, the only clock
//   reset_L      : asynchronous active-low reset
//   data_in      : serial data, MSB of each character first
//   data_out     : published frame, lane k in [k*WIDTH +: WIDTH]
//   valid_out    : per-lane valid of the published frame
//   frame_strobe : one-cycle pulse when data_out/valid_out update
//   idle_out     : one-cycle pulse per IDL decoded while synced
//   active       : high while synced
// A frame is published when the last lane slot is filled (by data or IDL) or
// when a COM closes a partially filled frame. A COM with nothing buffered
// publishes nothing.
// -----------------------------------------------------------------------------
module phy_rx_lanes
   import phy_rx_pkg::*;
#(
   parameter int               WIDTH      = 8,
   parameter int               NUM_LANES  = 4,
   parameter logic [WIDTH-1:0] COM_CHAR   = WIDTH'(DEFAULT_COM_CHAR),
   parameter logic [WIDTH-1:0] IDL_CHAR   = WIDTH'(DEFAULT_IDL_CHAR),
   parameter int               SYNC_COUNT = 4
) (
   input  logic                       clk_32f,
   input  logic                       reset_L,
   input  logic                       data_in,
   output logic [NUM_LANES*WIDTH-1:0] data_out,
   output logic [NUM_LANES-1:0]       valid_out,
   output logic                       frame_strobe,
   output logic                       idle_out,
   output logic                       active
);

   localparam int            PW       = ptr_width(NUM_LANES);
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_LANES - 1);

   logic [WIDTH-1:0]           rx_char;
   logic                       rx_stb;

   logic [PW-1:0]              ptr, ptr_nx;
   logic [NUM_LANES*WIDTH-1:0] slots, slots_nx;
   logic [NUM_LANES-1:0]       pend, pend_nx;
   logic                       publish;
   logic                       idle_nx;

   phy_rx_aligner #(
      .WIDTH      (WIDTH),
      .COM_CHAR   (COM_CHAR),
      .SYNC_COUNT (SYNC_COUNT)
   ) u_aligner (
      .clk_32f  (clk_32f),
      .reset_L  (reset_L),
      .data_in  (data_in),
      .char     (rx_char),
      .char_stb (rx_stb),
      .active   (active)
   );

   // slots_nx/pend_nx include the character being decoded, so a publish on
   // the last lane carries that lane too.
   always_comb begin
      ptr_nx   = ptr;
      slots_nx = slots;
      pend_nx  = pend;
      publish  = 1'b0;
      idle_nx  = 1'b0;

      if (rx_stb) begin
         if (rx_char == COM_CHAR) begin
            publish = (ptr != '0);
            ptr_nx  = '0;
         end else begin
            // Constant lane indices keep the selects in range for any lane count.
            for (int k = 0; k < NUM_LANES; k++) begin
               if (ptr == PW'(k)) begin
                  if (rx_char == IDL_CHAR) begin
                     pend_nx[k] = 1'b0;
                  end else begin
                     slots_nx[k*WIDTH +: WIDTH] = rx_char;
                     pend_nx[k]                 = 1'b1;
                  end
               end
            end
            idle_nx = (rx_char == IDL_CHAR);
            if (ptr == PTR_LAST) begin
               publish = 1'b1;
               ptr_nx  = '0;
            end else begin
               ptr_nx = ptr + 1'b1;
            end
         end
      end
   end

   // NOTE: the slot buffers are reset along with the control state so that a
   // reset mid-frame cannot leak stale characters into a later publish.
   always_ff @(posedge clk_32f or negedge reset_L) begin
      if (!reset_L) begin
         ptr          <= '0;
         slots        <= '0;
         pend         <= '0;
         data_out     <= '0;
         valid_out    <= '0;
         frame_strobe <= 1'b0;
         idle_out     <= 1'b0;
      end else begin
         ptr          <= ptr_nx;
         frame_strobe <= publish;
         idle_out     <= idle_nx;
         if (publish) begin
            data_out  <= slots_nx;
            valid_out <= pend_nx;
            slots     <= '0;
            pend      <= '0;
         end else begin
            slots     <= slots_nx;
            pend      <= pend_nx;
         end
      end
   end

endmodule
